// File: rtl/rv32i_types.sv
// Shared RV32 type package for the EX-stage M-extension path.
//   m_funct3_t   : funct3 encodings of the RV32M ops (only div/divu/rem/remu
//                  are meaningful to the divider).
//   div_state_t  : iterative divider control states.
//   is_signed_m  : true for the signed divide ops (div, rem).
//   is_rem_m     : true for the ops returning the remainder (rem, remu).
package rv32i_types;

  typedef enum logic [2:0] {
    mul    = 3'b000,
    mulh   = 3'b001,
    mulhsu = 3'b010,
    mulhu  = 3'b011,
    div    = 3'b100,
    divu   = 3'b101,
    rem    = 3'b110,
    remu   = 3'b111
  } m_funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FIXUP,
    DONE
  } div_state_t;

  function automatic logic is_signed_m(input m_funct3_t f);
    return (f == div) || (f == rem);
  endfunction

  function automatic logic is_rem_m(input m_funct3_t f);
    return (f == rem) || (f == remu);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on a {rem,quo} register.
//   rq_i      : {partial remainder, remaining dividend / quotient bits}
//   divisor_i : divisor magnitude
//   rq_o      : register after shift-left-by-one and conditional subtract
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] rq_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic [2*WIDTH-1:0] rq_o
);

  // The shifted partial remainder needs one extra bit: it may reach
  // 2*divisor-1, which can exceed WIDTH bits.
  logic [WIDTH:0]   upper;
  logic             ge;
  logic [WIDTH-1:0] rem_next;

  always_comb begin
    upper    = rq_i[2*WIDTH-1:WIDTH-1];
    ge       = (upper >= {1'b0, divisor_i});
    // When ge is set the true difference is below the divisor, so the
    // low WIDTH bits of the modular subtraction are exact.
    rem_next = ge ? (upper[WIDTH-1:0] - divisor_i) : upper[WIDTH-1:0];
    rq_o     = {rem_next, rq_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/rv_multi_divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : request, accepted only while ready
//   funct3     : op select, sampled on accept
//   dividend   : rs1, sampled on accept
//   divisor    : rs2, sampled on accept
//   flush      : kill in-flight op / block a simultaneous accept
//   ready      : high in IDLE only
//   div_done   : one-cycle result-valid pulse
//   quotient, remainder, result : valid with div_done, zero otherwise
// Divide-by-zero and signed overflow resolve at accept and go straight
// to DONE; other ops take WIDTH/BITS_PER_CYCLE SHIFT cycles plus FIXUP.
module rv_multi_divider
  import rv32i_types::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  m_funct3_t        funct3,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             ready,
  output logic             div_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned     STEPS   = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned     CW      = $clog2(STEPS + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t         state_q, state_d;
  logic [2*WIDTH-1:0] rq_q, rq_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic               is_rem_q, is_rem_d;
  logic [WIDTH-1:0]   quo_res_q, quo_res_d;
  logic [WIDTH-1:0]   rem_res_q, rem_res_d;

  logic               accept;
  logic               signed_in;
  logic               div_by_zero;
  logic               overflow;
  logic [WIDTH-1:0]   dividend_mag;
  logic [WIDTH-1:0]   divisor_mag;
  logic [2*WIDTH-1:0] chain [BITS_PER_CYCLE+1];

  // Unrolled restoring steps: BITS_PER_CYCLE quotient bits per SHIFT cycle.
  assign chain[0] = rq_q;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .rq_i      (chain[g]),
      .divisor_i (dvsr_q),
      .rq_o      (chain[g+1])
    );
  end

  always_comb begin
    accept       = start && (state_q == IDLE) && !flush;
    signed_in    = is_signed_m(funct3);
    div_by_zero  = (divisor == '0);
    overflow     = signed_in && (dividend == MIN_NEG) && (divisor == '1);
    dividend_mag = (signed_in && dividend[WIDTH-1]) ? -dividend : dividend;
    divisor_mag  = (signed_in && divisor[WIDTH-1])  ? -divisor  : divisor;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (div_by_zero || overflow) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (flush) begin
          state_d = IDLE;
        end else if (count_q == CW'(1)) begin
          state_d = FIXUP;
        end
      end
      FIXUP:   state_d = flush ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state
  always_comb begin
    rq_d      = rq_q;
    dvsr_d    = dvsr_q;
    count_d   = count_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    is_rem_d  = is_rem_q;
    quo_res_d = quo_res_q;
    rem_res_d = rem_res_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          is_rem_d = is_rem_m(funct3);
          if (div_by_zero) begin
            quo_res_d = '1;
            rem_res_d = dividend;
          end else if (overflow) begin
            quo_res_d = dividend;
            rem_res_d = '0;
          end else begin
            rq_d    = {{WIDTH{1'b0}}, dividend_mag};
            dvsr_d  = divisor_mag;
            neg_q_d = signed_in && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r_d = signed_in && dividend[WIDTH-1];
            count_d = CW'(STEPS);
          end
        end
      end
      SHIFT: begin
        rq_d    = chain[BITS_PER_CYCLE];
        count_d = count_q - CW'(1);
      end
      FIXUP: begin
        quo_res_d = neg_q_q ? -rq_q[WIDTH-1:0]       : rq_q[WIDTH-1:0];
        rem_res_d = neg_r_q ? -rq_q[2*WIDTH-1:WIDTH] : rq_q[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq_q      <= '0;
      dvsr_q    <= '0;
      count_q   <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      is_rem_q  <= 1'b0;
      quo_res_q <= '0;
      rem_res_q <= '0;
    end else begin
      rq_q      <= rq_d;
      dvsr_q    <= dvsr_d;
      count_q   <= count_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      is_rem_q  <= is_rem_d;
      quo_res_q <= quo_res_d;
      rem_res_q <= rem_res_d;
    end
  end

  // Outputs: results only visible during an unflushed DONE cycle.
  always_comb begin
    ready     = (state_q == IDLE);
    div_done  = (state_q == DONE) && !flush;
    quotient  = div_done ? quo_res_q : '0;
    remainder = div_done ? rem_res_q : '0;
    result    = div_done ? (is_rem_q ? rem_res_q : quo_res_q) : '0;
  end

endmodule

// File: doc/rv_multi_divider.md
Name: rv_multi_divider

Overview:
- Parametrised, iterative restoring divider for the M-extension path of the EX stage; next generation of the existing unsigned-only divider.
- Supports all four RV32M divide ops (DIV, DIVU, REM, REMU) with RISC-V-exact divide-by-zero and signed-overflow results.
- Configurable data width and bits retired per cycle. Adds a busy/ready handshake and a flush input so the pipeline can kill an in-flight divide.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and at least 8.
- BITS_PER_CYCLE, 1, quotient bits produced per SHIFT cycle; legal values 1, 2, 4; must divide WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- funct3  in  m_funct3_t  op select (div, divu, rem, remu); sampled on accept.
- dividend  in  WIDTH  rs1; sampled on accept.
- divisor  in  WIDTH  rs2; sampled on accept.
- flush  in  1  abort in-flight op.
- ready  out  1  high in IDLE only.
- div_done  out  1  one-cycle pulse; result valid this cycle.
- quotient  out  WIDTH  final quotient; '0 when div_done=0.
- remainder  out  WIDTH  final remainder; '0 when div_done=0.
- result  out  WIDTH  quotient for div/divu, remainder for rem/remu; '0 when div_done=0.

Behaviour:
- Reset (async assert, any state): state=IDLE, data/divisor/count/sign flags cleared, ready=1, div_done=0, all results 0.
- States: IDLE, SHIFT, FIXUP, DONE.
- Accept: start && ready (IDLE). Capture signed_op = (funct3==div || funct3==rem).
- Divisor==0 on accept: next state DONE; quotient = all ones; remainder = dividend (raw, unsigned and signed alike).
- Signed overflow on accept (signed_op, dividend = 1 followed by WIDTH-1 zeros, divisor = all ones): next state DONE; quotient = dividend; remainder = 0. Divide-by-zero check takes priority.
- Normal accept:
  - Load magnitudes (two's-complement negate if signed_op and MSB set).
  - neg_q = signed_op & (dividend MSB ^ divisor MSB).
  - neg_r = signed_op & dividend MSB.
  - count = WIDTH/BITS_PER_CYCLE; go to SHIFT.
- SHIFT: per cycle, BITS_PER_CYCLE unrolled restoring steps on a 2*WIDTH {rem,quo} register. Each step:
  - shift left 1;
  - if upper half >= divisor, subtract and set quo LSB.
  - Decrement count; at count==1 go to FIXUP.
- FIXUP: conditionally negate quotient (neg_q) and remainder (neg_r); register results; go to DONE.
- DONE: div_done=1 and results driven from registers for exactly this cycle; next state IDLE.
- Latency from accept cycle to div_done:
  - normal: WIDTH/BITS_PER_CYCLE + 2 cycles (34 for defaults);
  - special cases: 1 cycle.
- Throughput: ready rises the cycle after DONE, so back-to-back ops need one idle gap. start while ready=0 is ignored, not queued.
- Flush:
  - In SHIFT/FIXUP/DONE: next state IDLE, no div_done.
  - In DONE: suppresses div_done that cycle.
  - In IDLE: blocks accept of a simultaneous start.
- Inputs may change after accept without affecting the result; nothing is combinationally forwarded from operand inputs to outputs.
- Remainder sign always follows the dividend; |remainder| < |divisor|.

Decomposition:
- rv32i_types (shared package): m_funct3_t, plus div_state_t enum and helper function is_signed_m(funct3).
- One natural sub-module: div_step, a combinational single restoring iteration (WIDTH param), instantiated BITS_PER_CYCLE times in a generate chain.

Test Plan:
- Cases below use defaults unless noted.
- DIVU 100/7 -> quotient=14, remainder=2, result=14; div_done exactly 34 cycles after accept; ready low throughout.
- DIV -7/2 (0xFFFFFFF9, 2) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); REM same operands -> result=0xFFFFFFFF.
- DIV by zero: 0x12345678/0 -> quotient=0xFFFFFFFF, remainder=0x12345678, div_done 1 cycle after accept. Then DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, 1-cycle latency.
- Flush at SHIFT cycle 10 of DIVU 1000/3 -> no div_done, ready=1 next cycle. A new DIVU 9/3 then completes with quotient=3, remainder=0.
- Async rst asserted mid-SHIFT, off-clock-edge -> ready=1, outputs 0 immediately; start ignored while rst=1.
- WIDTH=16, BITS_PER_CYCLE=4: REMU 0xFFFF/0x0010 -> remainder=0x000F, div_done 6 cycles after accept. Random signed/unsigned regression checked against a reference model.
